// File: rtl/gray_sobel_pkg.sv
// rtl/gray_sobel_pkg.sv - shared pixel/window types and default image geometry
package gray_sobel_pkg;
    localparam int MAX_PIXEL_BITS = 8;
    localparam int IMG_WIDTH      = 16;
    localparam int IMG_HEIGHT     = 16;

    typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;
    typedef pixel_t [8:0]              window_t;
endpackage

// File: rtl/px_line_buffer.sv
// rtl/px_line_buffer.sv - enable-gated pixel delay line of DEPTH stages
module px_line_buffer
    import gray_sobel_pkg::*;
#(
    parameter int DEPTH = gray_sobel_pkg::IMG_WIDTH
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   en_i,
    input  pixel_t pixel_i,
    output pixel_t pixel_o
);
    pixel_t [DEPTH-1:0] sr_q;
    pixel_t [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d = {sr_q[DEPTH-2:0], pixel_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign pixel_o = sr_q[DEPTH-1];
endmodule

// File: rtl/px_window_3x3.sv
// rtl/px_window_3x3.sv - streaming 3x3 window generator with frame position tracking
module px_window_3x3
    import gray_sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = gray_sobel_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = gray_sobel_pkg::IMG_HEIGHT
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0]   in_pixel_i,
    output logic [9*MAX_PIXEL_BITS-1:0] window_o,
    output logic                        window_valid_o,
    output logic                        frame_done_o,
    output logic                        busy_o
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             accept, last_px, emit;
    window_t          win_q, win_d, win_o_q, win_o_d;
    pixel_t           lb0_out, lb1_out;

    px_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .pixel_i (in_pixel_i),
        .pixel_o (lb0_out)
    );

    px_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .pixel_i (lb0_out),
        .pixel_o (lb1_out)
    );

    // start_i wins: the strobed pixel of a start cycle is treated as (0,0).
    always_comb begin
        accept  = px_rdy_i && (busy_q || start_i);
        col_cur = start_i ? '0 : col_q;
        row_cur = start_i ? '0 : row_q;
        last_px = (col_cur == COL_W'(IMG_WIDTH - 1)) && (row_cur == ROW_W'(IMG_HEIGHT - 1));
        emit    = accept && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));

        col_d  = col_cur;
        row_d  = row_cur;
        busy_d = busy_q || start_i;
        if (accept) begin
            if (last_px) begin
                col_d  = '0;
                row_d  = '0;
                busy_d = 1'b0;
            end else if (col_cur == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = row_cur + ROW_W'(1);
            end else begin
                col_d = col_cur + COL_W'(1);
            end
        end
        valid_d = emit;
        done_d  = accept && last_px;
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb1_out;
            win_d[5] = lb0_out;
            win_d[8] = in_pixel_i;
        end
        win_o_d = emit ? win_d : win_o_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '0;
            win_o_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
            win_o_q <= win_o_d;
        end
    end

    assign window_o       = win_o_q;
    assign window_valid_o = valid_q;
    assign frame_done_o   = done_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_px_window_3x3.sv
// tb/tb_px_window_3x3.sv - scoreboard bench for px_window_3x3 (4x4 and 5x3 geometries)
module tb_px_window_3x3;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        px_rdy = 1'b0;
    logic [7:0]  in_pixel = 8'h00;
    logic [71:0] win_a, win_b;
    logic        valid_a, valid_b, done_a, done_b, busy_a, busy_b;

    logic        sel = 1'b0;
    logic        mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pulses = 0;

    int          mw, mh, m_row, m_col;
    logic        m_busy = 1'b0;
    logic        e_done = 1'b0;
    logic [7:0]  img [0:15][0:15];
    logic [71:0] exp_win_q [$];
    int          exp_cyc_q [$];

    always #5 clk = ~clk;

    px_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .px_rdy_i(px_rdy),
        .in_pixel_i(in_pixel), .window_o(win_a), .window_valid_o(valid_a),
        .frame_done_o(done_a), .busy_o(busy_a)
    );

    px_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut53 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .px_rdy_i(px_rdy),
        .in_pixel_i(in_pixel), .window_o(win_b), .window_valid_o(valid_b),
        .frame_done_o(done_b), .busy_o(busy_b)
    );

    wire [71:0] o_win   = sel ? win_b   : win_a;
    wire        o_valid = sel ? valid_b : valid_a;
    wire        o_done  = sel ? done_b  : done_a;
    wire        o_busy  = sel ? busy_b  : busy_a;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model: tracks the frame position and records pixels by (row,col).
    always @(posedge clk) begin
        logic        acc;
        logic [71:0] w;
        cyc++;
        mw = sel ? 5 : 4;
        mh = sel ? 3 : 4;
        e_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_row  = 0;
            m_col  = 0;
        end else begin
            acc = px_rdy && (m_busy || start);
            if (start) begin
                m_row  = 0;
                m_col  = 0;
                m_busy = 1'b1;
            end
            if (acc) begin
                img[m_row][m_col] = in_pixel;
                if (m_row >= 2 && m_col >= 2) begin
                    for (int k = 0; k < 9; k++)
                        w[k*8 +: 8] = img[m_row - 2 + k/3][m_col - 2 + k%3];
                    exp_win_q.push_back(w);
                    exp_cyc_q.push_back(cyc);
                end
                if (m_row == mh - 1 && m_col == mw - 1) begin
                    e_done = 1'b1;
                    m_busy = 1'b0;
                    m_row  = 0;
                    m_col  = 0;
                end else if (m_col == mw - 1) begin
                    m_col = 0;
                    m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("busy", o_busy, m_busy);
            check_eq("frame_done", o_done, e_done);
            if (o_valid) begin
                pulses++;
                if (exp_win_q.size() == 0) begin
                    check_eq("spurious_valid", o_valid, 1'b0);
                end else begin
                    check_eq("window", o_win, exp_win_q.pop_front());
                    check_eq("latency", cyc, exp_cyc_q.pop_front());
                end
            end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                check_eq("missing_valid", o_valid, 1'b1);
                void'(exp_win_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    task automatic drive(input logic st, input logic rdy, input logic [7:0] px);
        start    = st;
        px_rdy   = rdy;
        in_pixel = px;
        @(posedge clk);
        #1;
        start  = 1'b0;
        px_rdy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1, 8'hAA);
        reset = 1'b0;
        check_eq("rst_window", o_win, 72'h0);
        check_eq("rst_valid", o_valid, 1'b0);
    endtask

    task automatic run_frame(input int w, input int h, input int max_gap, input bit st_with_first);
        if (!st_with_first) drive(1, 0, 8'h00);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) drive(0, 0, 8'h00);
                drive(st_with_first && r == 0 && c == 0, 1, 8'(16*r + c));
            end
        end
        repeat (3) drive(0, 0, 8'h00);
    endtask

    initial begin
        logic [71:0] first_win;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        check_eq("reset_busy", o_busy, 1'b0);
        check_eq("reset_window", o_win, 72'h0);

        // 1: back-to-back frame
        pulses = 0;
        drive(1, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 8'(16*(i/4) + i%4));
            if (i == 10) first_win = o_win;
        end
        check_eq("first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
        repeat (3) drive(0, 0, 8'h00);
        check_eq("t1_pulses", pulses, 4);
        check_eq("window_hold", o_win, 72'h33_32_31_23_22_21_13_12_11);

        // 2: random idle gaps
        pulses = 0;
        run_frame(4, 4, 3, 0);
        check_eq("t2_pulses", pulses, 4);

        // 3: strobes while idle are ignored
        pulses = 0;
        for (int i = 0; i < 6; i++) drive(0, 1, 8'hF0 + 8'(i));
        check_eq("t3_idle_pulses", pulses, 0);
        run_frame(4, 4, 0, 0);
        check_eq("t3_pulses", pulses, 4);

        // 4: start together with pixel (0,0)
        pulses = 0;
        run_frame(4, 4, 0, 1);
        check_eq("t4_pulses", pulses, 4);

        // restart while busy: new frame position from (0,0)
        pulses = 0;
        drive(1, 0, 8'h00);
        for (int i = 0; i < 7; i++) drive(0, 1, 8'h80 + 8'(i));
        run_frame(4, 4, 1, 1);
        check_eq("restart_pulses", pulses, 4);

        // 5: reset after pixel 0x21
        pulses = 0;
        drive(1, 0, 8'h00);
        for (int i = 0; i < 10; i++) drive(0, 1, 8'(16*(i/4) + i%4));
        reset = 1'b1;
        drive(0, 1, 8'h22);
        reset = 1'b0;
        check_eq("t5_window", o_win, 72'h0);
        check_eq("t5_valid", o_valid, 1'b0);
        check_eq("t5_done", o_done, 1'b0);
        repeat (2) drive(0, 0, 8'h00);
        check_eq("t5_no_pulse", pulses, 0);
        run_frame(4, 4, 0, 0);
        check_eq("t5_pulses", pulses, 4);

        // 6: 5x3 geometry
        sel = 1'b1;
        do_reset();
        pulses = 0;
        run_frame(5, 3, 2, 0);
        check_eq("t6_pulses", pulses, 3);
        check_eq("t6_last_window", o_win, 72'h24_23_22_14_13_12_04_03_02);

        check_eq("queue_empty", exp_win_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
